stage_monitor: RTL

STAGE_MONITOR -- requirements
Module: stage_monitor

---
 rtl/stage_monitor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/stage_monitor.sv
// Checks the pipeline sequencer strobes against the expected phase each cycle; flags and records the first violation.
// Outputs are registered with latency 1. Optional macro STAGE_MONITOR_PC_STROBE_EN adds pc_wren to the WB_IF expected set.
module stage_monitor (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stage_reset_n,
  input  logic        pc_wren,
  input  logic        wb_if_wren,
  input  logic        if_id_wren,
  input  logic        id_ex_wren,
  input  logic        ex_mem_wren,
  input  logic        ram_wren,
  input  logic        mem_wb_wren,
  input  logic        reg_wren,
  output logic [3:0]  phase,
  output logic        instr_done,
  output logic [31:0] retire_count,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [3:0]  err_phase
);

  typedef enum logic [3:0] {
    PH_INIT   = 4'd0,
    PH_IF     = 4'd1,
    PH_IF_ID  = 4'd2,
    PH_ID     = 4'd3,
    PH_ID_EX  = 4'd4,
    PH_EX_MEM = 4'd5,
    PH_MEM    = 4'd6,
    PH_MEM_WB = 4'd7,
    PH_WB     = 4'd8,
    PH_WB_IF  = 4'd9,
    PH_FAULT  = 4'd15
  } phase_t;

  localparam logic [1:0] CODE_INIT_STROBE = 2'd1;
  localparam logic [1:0] CODE_MISSING     = 2'd2;
  localparam logic [1:0] CODE_UNEXPECTED  = 2'd3;

  // Strobe vector bit order: pc, wb_if, if_id, id_ex, ex_mem, ram, mem_wb, reg
  localparam logic [7:0] S_PC     = 8'b1000_0000;
  localparam logic [7:0] S_WB_IF  = 8'b0100_0000;
  localparam logic [7:0] S_IF_ID  = 8'b0010_0000;
  localparam logic [7:0] S_ID_EX  = 8'b0001_0000;
  localparam logic [7:0] S_EX_MEM = 8'b0000_1000;
  localparam logic [7:0] S_RAM    = 8'b0000_0100;
  localparam logic [7:0] S_MEM_WB = 8'b0000_0010;
  localparam logic [7:0] S_REG    = 8'b0000_0001;

  phase_t     state;
  phase_t     next_state;
  logic [7:0] strobes;
  logic [7:0] exp_mask;
  logic       unexpected;
  logic       missing;
  logic       viol;
  logic [1:0] viol_code;
  logic       retire;

  assign strobes = {pc_wren, wb_if_wren, if_id_wren, id_ex_wren,
                    ex_mem_wren, ram_wren, mem_wb_wren, reg_wren};

  always_comb begin
    exp_mask = 8'd0;
    case (state)
      PH_IF_ID:  exp_mask = S_IF_ID;
      PH_ID_EX:  exp_mask = S_ID_EX;
      PH_EX_MEM: exp_mask = S_EX_MEM;
      PH_MEM:    exp_mask = S_RAM;
      PH_MEM_WB: exp_mask = S_MEM_WB;
      PH_WB:     exp_mask = S_REG;
`ifdef STAGE_MONITOR_PC_STROBE_EN
      PH_WB_IF:  exp_mask = S_WB_IF | S_PC;
`else
      PH_WB_IF:  exp_mask = S_WB_IF;
`endif
      default:   exp_mask = 8'd0;
    endcase
  end

  assign unexpected = |(strobes & ~exp_mask);
  assign missing    = |(exp_mask & ~strobes);

  always_comb begin
    next_state = state;
    viol       = 1'b0;
    viol_code  = 2'd0;
    retire     = 1'b0;
    if (state == PH_FAULT) begin
      // No checking while faulted; only a sequencer stage reset leaves.
      if (!stage_reset_n) begin
        next_state = PH_INIT;
      end
    end else if (!stage_reset_n) begin
      if (|strobes) begin
        viol       = 1'b1;
        viol_code  = CODE_INIT_STROBE;
        next_state = PH_FAULT;
      end else begin
        next_state = PH_INIT;
      end
    end else if (unexpected) begin
      viol       = 1'b1;
      viol_code  = CODE_UNEXPECTED;
      next_state = PH_FAULT;
    end else if (missing) begin
      viol       = 1'b1;
      viol_code  = CODE_MISSING;
      next_state = PH_FAULT;
    end else begin
      case (state)
        PH_INIT:   next_state = PH_IF;
        PH_WB_IF: begin
          next_state = PH_IF;
          retire     = 1'b1;
        end
        PH_IF, PH_IF_ID, PH_ID, PH_ID_EX, PH_EX_MEM,
        PH_MEM, PH_MEM_WB, PH_WB:
                   next_state = phase_t'(state + 4'd1);
        default:   next_state = PH_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= PH_INIT;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_done   <= 1'b0;
      retire_count <= 32'd0;
      error        <= 1'b0;
      err_code     <= 2'd0;
      err_phase    <= 4'd0;
    end else begin
      instr_done <= retire;
      if (retire) begin
        retire_count <= retire_count + 32'd1;
      end
      // Only the first violation's cause is kept until a full reset.
      if (viol) begin
        error <= 1'b1;
        if (!error) begin
          err_code  <= viol_code;
          err_phase <= state;
        end
      end
    end
  end

  assign phase = state;

endmodule
